// File: rtl/ah_packet_converter_w2n_param.sv
// ---------------------------------------------------------------------------
// ah_packet_converter_w2n_param
//
// Wide-to-narrow stream width converter with packet framing. IN_W-bit input
// words are serialised LSB-first into OUT_W-bit output beats. The ratio does
// not need to be an integer. On the last word of a packet, any residual bits
// are flushed as a zero-padded final beat tagged m_last. m_nbits reports how
// many LSBs of that beat are valid.
//
// Ports
//   clk      in   1      clock, rising edge
//   rstn     in   1      asynchronous active-low reset
//   s_data   in   IN_W   input word, bit 0 is the earliest stream bit
//   s_valid  in   1      input word valid
//   s_last   in   1      input word closes the packet
//   s_ready  out  1      word is accepted this cycle (depends on state only)
//   m_data   out  OUT_W  output beat, bit 0 is the earliest bit, zero padded
//   m_valid  out  1      output beat valid
//   m_last   out  1      final beat of the packet
//   m_nbits  out  NB_W   count of valid LSBs in m_data
//   m_ready  in   1      downstream takes the beat
// ---------------------------------------------------------------------------
module ah_packet_converter_w2n_param #(
    parameter  int IN_W  = 15,
    parameter  int OUT_W = 10,
    localparam int BUF_W = IN_W + OUT_W - 1,
    localparam int CNT_W = $clog2(BUF_W + 1),
    localparam int NB_W  = $clog2(OUT_W + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [IN_W-1:0]  s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    output logic [NB_W-1:0]  m_nbits,
    input  logic             m_ready
);

    localparam logic [CNT_W-1:0] OUT_C = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] IN_C  = CNT_W'(IN_W);

    // Residue buffer: bits [fill_q-1:0] are valid, everything above is kept 0.
    logic [BUF_W-1:0] buf_q;
    logic [CNT_W-1:0] fill_q;
    logic             pend_last_q;

    logic             full;
    logic             accept;
    logic             emit;
    logic [BUF_W-1:0] keep_mask;
    logic [BUF_W-1:0] ins_word;
    logic [OUT_W-1:0] beat_mask;

    always_comb begin
        full    = (fill_q >= OUT_C);
        m_valid = full || (pend_last_q && (fill_q != '0));
        m_last  = pend_last_q && (fill_q <= OUT_C);
        m_nbits = full ? NB_W'(OUT_W) : NB_W'(fill_q);

        // Only bits below fill are meaningful. Masking here keeps the zero-pad
        // guarantee independent of what the shift leaves in the upper bits.
        beat_mask = '0;
        for (int i = 0; i < OUT_W; i++)
            beat_mask[i] = (CNT_W'(i) < fill_q);
        m_data = buf_q[OUT_W-1:0] & beat_mask;

        // Accept is allowed only while fewer than OUT_W bits are pending, so
        // fill + IN_W never exceeds BUF_W. This also keeps accept and emit
        // mutually exclusive.
        s_ready = rstn && !full && !pend_last_q;
    end

    always_comb begin
        keep_mask = '0;
        for (int i = 0; i < BUF_W; i++)
            keep_mask[i] = (CNT_W'(i) < fill_q);
        ins_word = BUF_W'(s_data) << fill_q;
    end

    assign accept = s_valid && s_ready;
    assign emit   = m_valid && m_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_q       <= '0;
            fill_q      <= '0;
            pend_last_q <= 1'b0;
        end else if (accept) begin
            buf_q       <= (buf_q & keep_mask) | ins_word;
            fill_q      <= fill_q + IN_C;
            pend_last_q <= s_last;
        end else if (emit) begin
            buf_q <= buf_q >> OUT_W;
            if (m_last) begin
                // The final beat drains the buffer completely, including an
                // exact-multiple full beat, so no trailing empty beat follows.
                fill_q      <= '0;
                pend_last_q <= 1'b0;
            end else begin
                fill_q <= fill_q - CNT_W'(m_nbits);
            end
        end
    end

endmodule

// File: tb/tb_ah_packet_converter_w2n_param.sv
// Testbench for ah_packet_converter_w2n_param. Four converter ratios share one
// stimulus and checking path, selected by sel. Expected beats are derived by
// slicing the packet's flat bitstream.
module tb_ah_packet_converter_w2n_param;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] s_data;
    logic        s_valid, s_last, m_ready;
    int          sel;

    always #5 clk = ~clk;

    // 0: 15->10, 1: 8->8, 2: 32->7, 3: 9->1
    logic [9:0] md0; logic [3:0] mn0; logic mv0, ml0, sr0;
    logic [7:0] md1; logic [3:0] mn1; logic mv1, ml1, sr1;
    logic [6:0] md2; logic [2:0] mn2; logic mv2, ml2, sr2;
    logic [0:0] md3; logic [0:0] mn3; logic mv3, ml3, sr3;

    ah_packet_converter_w2n_param #(.IN_W(15), .OUT_W(10)) u_dut0 (
        .clk(clk), .rstn(rstn), .s_data(s_data[14:0]), .s_valid(s_valid && sel == 0),
        .s_last(s_last), .s_ready(sr0), .m_data(md0), .m_valid(mv0), .m_last(ml0),
        .m_nbits(mn0), .m_ready(m_ready && sel == 0));
    ah_packet_converter_w2n_param #(.IN_W(8), .OUT_W(8)) u_dut1 (
        .clk(clk), .rstn(rstn), .s_data(s_data[7:0]), .s_valid(s_valid && sel == 1),
        .s_last(s_last), .s_ready(sr1), .m_data(md1), .m_valid(mv1), .m_last(ml1),
        .m_nbits(mn1), .m_ready(m_ready && sel == 1));
    ah_packet_converter_w2n_param #(.IN_W(32), .OUT_W(7)) u_dut2 (
        .clk(clk), .rstn(rstn), .s_data(s_data[31:0]), .s_valid(s_valid && sel == 2),
        .s_last(s_last), .s_ready(sr2), .m_data(md2), .m_valid(mv2), .m_last(ml2),
        .m_nbits(mn2), .m_ready(m_ready && sel == 2));
    ah_packet_converter_w2n_param #(.IN_W(9), .OUT_W(1)) u_dut3 (
        .clk(clk), .rstn(rstn), .s_data(s_data[8:0]), .s_valid(s_valid && sel == 3),
        .s_last(s_last), .s_ready(sr3), .m_data(md3), .m_valid(mv3), .m_last(ml3),
        .m_nbits(mn3), .m_ready(m_ready && sel == 3));

    logic [31:0] o_data;
    logic [7:0]  o_nb;
    logic        o_valid, o_last, o_sready;

    always_comb begin
        o_data = '0; o_nb = '0; o_valid = 1'b0; o_last = 1'b0; o_sready = 1'b0;
        case (sel)
            0: begin o_data = 32'(md0); o_nb = 8'(mn0); o_valid = mv0; o_last = ml0; o_sready = sr0; end
            1: begin o_data = 32'(md1); o_nb = 8'(mn1); o_valid = mv1; o_last = ml1; o_sready = sr1; end
            2: begin o_data = 32'(md2); o_nb = 8'(mn2); o_valid = mv2; o_last = ml2; o_sready = sr2; end
            default: begin o_data = 32'(md3); o_nb = 8'(mn3); o_valid = mv3; o_last = ml3; o_sready = sr3; end
        endcase
    end

    int n_chk = 0;
    int n_err = 0;
    int rx_cnt;

    logic [31:0] pkt_q[$];
    logic [31:0] exp_d[$];
    int          exp_n[$];
    bit          exp_l[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Flatten the packet into a bit list, then cut it into ow-bit beats.
    task automatic build_exp(input int iw, input int ow);
        bit bits[$];
        int total, nb;
        logic [31:0] w, d;
        exp_d.delete(); exp_n.delete(); exp_l.delete();
        foreach (pkt_q[i]) begin
            w = pkt_q[i];
            for (int b = 0; b < iw; b++) bits.push_back(w[b]);
        end
        total = bits.size();
        nb    = (total + ow - 1) / ow;
        for (int k = 0; k < nb; k++) begin
            d = '0;
            for (int j = 0; j < ow; j++)
                if (k * ow + j < total) d[j] = bits[k * ow + j];
            exp_d.push_back(d);
            exp_n.push_back((total - k * ow) < ow ? (total - k * ow) : ow);
            exp_l.push_back(k == nb - 1);
        end
    endtask

    function automatic logic [31:0] wmask(input int iw);
        logic [31:0] m;
        m = (iw >= 32) ? 32'hFFFF_FFFF : ((32'h1 << iw) - 32'h1);
        return m;
    endfunction

    // Drive pkt_q into the selected converter and check every beat.
    // stall_n >= 0: hold m_ready low for stall_n cycles on each beat.
    task automatic run_pkt(input int iw, input int ow, input int vprob,
                           input int rprob, input int stall_n);
        int wi, bi, cyc, wait_cnt, n;
        bit mv, ml, sr, rdy, sv, stalled;
        logic [31:0] md, pd;
        logic [7:0]  mn, pn;
        bit pl;
        build_exp(iw, ow);
        n = pkt_q.size();
        wi = 0; bi = 0; cyc = 0; wait_cnt = 0; stalled = 0;
        pd = '0; pn = '0; pl = 0;
        while ((wi < n || bi < exp_d.size()) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            mv = o_valid; ml = o_last; sr = o_sready; md = o_data; mn = o_nb;
            if (mv && sr) chk("ready_while_valid", 32'(sr), 32'd0);
            if (stalled) begin
                chk("hold_valid", 32'(mv), 32'd1);
                chk("hold_data", md, pd);
                chk("hold_nbits", 32'(mn), 32'(pn));
                chk("hold_last", 32'(ml), 32'(pl));
            end
            if (stall_n >= 0) begin
                rdy = 0;
                if (mv) begin
                    if (wait_cnt < stall_n) wait_cnt++;
                    else begin rdy = 1; wait_cnt = 0; end
                end
            end else begin
                rdy = ($urandom_range(0, 99) < rprob);
            end
            if (mv && rdy) begin
                if (bi < exp_d.size()) begin
                    chk("beat_data", md, exp_d[bi]);
                    chk("beat_nbits", 32'(mn), 32'(exp_n[bi]));
                    chk("beat_last", 32'(ml), 32'(exp_l[bi]));
                end else begin
                    chk("extra_beat", 32'd1, 32'd0);
                end
                bi++;
            end
            sv = (wi < n) && ($urandom_range(0, 99) < vprob);
            s_data  = (wi < n) ? pkt_q[wi] : 32'h0;
            s_last  = (wi == n - 1);
            if (sv && sr) wi++;
            stalled = mv && !rdy;
            pd = md; pn = mn; pl = ml;
            s_valid = sv;
            m_ready = rdy;
        end
        if (cyc >= 4000) chk("timeout", 32'd0, 32'd1);
        rx_cnt = bi;
        @(negedge clk);
        s_valid = 0; m_ready = 0; s_last = 0;
        @(negedge clk);
        chk("idle_sready", 32'(o_sready), 32'd1);
        chk("idle_mvalid", 32'(o_valid), 32'd0);
    endtask

    initial begin
        int iw_t[4], ow_t[4];
        iw_t = '{15, 8, 32, 9};
        ow_t = '{10, 8, 7, 1};
        rstn = 0; s_valid = 0; s_last = 0; s_data = '0; m_ready = 0; sel = 0;
        #1;
        chk("rst_mvalid", 32'(o_valid), 32'd0);
        chk("rst_sready", 32'(o_sready), 32'd0);
        chk("rst_mdata", o_data, 32'd0);
        chk("rst_mnbits", 32'(o_nb), 32'd0);
        chk("rst_mlast", 32'(o_last), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1;
        @(negedge clk);
        chk("post_rst_sready", 32'(o_sready), 32'd1);

        // single-word packet with a short final beat
        pkt_q = '{32'h1234};
        run_pkt(15, 10, 100, 100, -1);
        chk("c1_beats", 32'(rx_cnt), 32'd2);

        // exact multiple: no trailing empty beat
        pkt_q = '{32'h7FFF, 32'h0000};
        run_pkt(15, 10, 100, 100, -1);
        chk("c2_beats", 32'(rx_cnt), 32'd3);

        // the same packet under 5-cycle backpressure on each beat
        run_pkt(15, 10, 100, 100, 5);
        chk("c3_beats", 32'(rx_cnt), 32'd3);

        // reset in the middle of a packet
        @(negedge clk);
        chk("c4_sready", 32'(o_sready), 32'd1);
        s_data = 32'h7FFF; s_last = 0; s_valid = 1;
        @(negedge clk);
        s_valid = 0;
        chk("c4_mvalid", 32'(o_valid), 32'd1);
        chk("c4_mdata", o_data, 32'h3FF);
        rstn = 0;
        #1;
        chk("c4_rst_mvalid", 32'(o_valid), 32'd0);
        chk("c4_rst_sready", 32'(o_sready), 32'd0);
        chk("c4_rst_mdata", o_data, 32'd0);
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        chk("c4_post_sready", 32'(o_sready), 32'd1);
        chk("c4_post_mvalid", 32'(o_valid), 32'd0);
        pkt_q = '{32'h7FFF, 32'h0000};
        run_pkt(15, 10, 100, 100, -1);
        chk("c4_beats", 32'(rx_cnt), 32'd3);

        // equal widths behave as a registered pass-through
        sel = 1;
        pkt_q = '{32'hA5, 32'h3C};
        run_pkt(8, 8, 100, 100, -1);
        chk("c5_beats", 32'(rx_cnt), 32'd2);

        // random packets, valid and ready patterns for every ratio
        for (int s = 0; s < 4; s++) begin
            sel = s;
            for (int p = 0; p < 8; p++) begin
                int n;
                n = $urandom_range(1, 6);
                pkt_q.delete();
                for (int k = 0; k < n; k++) pkt_q.push_back($urandom() & wmask(iw_t[s]));
                run_pkt(iw_t[s], ow_t[s], $urandom_range(30, 100), $urandom_range(30, 100), -1);
                chk("rnd_beats", 32'(rx_cnt), 32'((n * iw_t[s] + ow_t[s] - 1) / ow_t[s]));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
